// File: rtl/fifo_stream_reader_pkg.sv
// Shared defaults, width helper and event type for the FIFO-to-AXI4-Stream reader.
package fifo_stream_reader_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_RD_LATENCY = 1;
    localparam int DEF_BUF_DEPTH  = 4;
    localparam int DEF_PACKET_LEN = 0;
    localparam int DEF_CNT_WIDTH  = 16;

    // Occupancy must be able to represent a completely full buffer.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic land;  // a returning FIFO word is written into the buffer
        logic pop;   // stream handshake removes the buffer head
    } buf_evt_t;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus AXI4-Stream master bundled as one handshake interface.
interface fifo_stream_reader_if
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_empty_n;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_data,
        input  fifo_empty_n,
        output m_axis_tdata,
        output m_axis_tvalid,
        input  m_axis_tready,
        output m_axis_tlast
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_data,
        output fifo_empty_n,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        output m_axis_tready,
        input  m_axis_tlast
    );
endinterface

// File: rtl/fifo_stream_reader_reg_fifo.sv
// Small register FIFO with count/full/empty; head word is visible combinationally.
module reg_fifo
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_BUF_DEPTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en_i,
    input  logic [DATA_WIDTH-1:0]         wr_data_i,
    input  logic                          rd_en_i,
    output logic [DATA_WIDTH-1:0]         rd_data_o,
    output logic [occ_width(DEPTH)-1:0]   count_o,
    output logic                          full_o,
    output logic                          empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = occ_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  wr_ok;
    logic                  rd_ok;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    // A simultaneous read frees the slot, so writing while full is legal then.
    assign wr_ok = wr_en_i && (!full_o || rd_en_i);
    assign rd_ok = rd_en_i && !empty_o;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(wr_en_i && full_o && !rd_en_i));

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a fixed-latency FIFO read port into an AXI4-Stream master with an output
// buffer sized so that every issued read always has a slot to land in.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int BUF_DEPTH  = DEF_BUF_DEPTH,
    parameter int PACKET_LEN = DEF_PACKET_LEN,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    fifo_stream_reader_if.master       bus,
    output logic [$clog2(BUF_DEPTH):0] occupancy
);
    localparam int OCC_W = occ_width(BUF_DEPTH);
    localparam logic [CNT_WIDTH-1:0] LAST_IDX =
        CNT_WIDTH'((PACKET_LEN == 0) ? 0 : PACKET_LEN - 1);

    logic [OCC_W-1:0]      occ_q;
    logic [OCC_W-1:0]      occ_d;
    logic [RD_LATENCY-1:0] vpipe_q;
    logic [RD_LATENCY-1:0] vpipe_d;
    logic [CNT_WIDTH-1:0]  beat_q;
    logic [CNT_WIDTH-1:0]  beat_d;
    buf_evt_t              evt;
    logic                  rd_en;
    logic                  last_beat;
    logic [DATA_WIDTH-1:0] buf_head;
    logic [OCC_W-1:0]      buf_count;
    logic                  buf_full;
    logic                  buf_empty;

    // Occupancy counts words already requested, so a read is only issued
    // when a buffer slot is guaranteed even if the sink never drains.
    assign rd_en = !reset && bus.fifo_empty_n && (occ_q < OCC_W'(BUF_DEPTH));

    always_comb begin
        evt      = '0;
        evt.land = vpipe_q[RD_LATENCY-1];
        evt.pop  = !buf_empty && bus.m_axis_tready;
    end

    assign vpipe_d[0] = rd_en;
    generate
        for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_vpipe
            assign vpipe_d[gi] = vpipe_q[gi-1];
        end
    endgenerate

    always_comb begin
        occ_d = occ_q;
        case ({rd_en, evt.pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    assign last_beat = (PACKET_LEN != 0) && (beat_q == LAST_IDX);

    always_comb begin
        beat_d = beat_q;
        if (evt.pop) begin
            beat_d = last_beat ? '0 : beat_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vpipe_q <= '0;
            occ_q   <= '0;
            beat_q  <= '0;
        end else begin
            vpipe_q <= vpipe_d;
            occ_q   <= occ_d;
            beat_q  <= beat_d;
        end
    end

    reg_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (evt.land),
        .wr_data_i (bus.fifo_rd_data),
        .rd_en_i   (evt.pop),
        .rd_data_o (buf_head),
        .count_o   (buf_count),
        .full_o    (buf_full),
        .empty_o   (buf_empty)
    );

    // Data and last are forced low while nothing is buffered so reset leaves clean outputs.
    assign bus.fifo_rd_en    = rd_en;
    assign bus.m_axis_tvalid = !buf_empty;
    assign bus.m_axis_tdata  = buf_empty ? '0 : buf_head;
    assign bus.m_axis_tlast  = !buf_empty && last_beat;
    assign occupancy         = occ_q;

    a_land_has_room: assert property (@(posedge clk) disable iff (reset)
        !(evt.land && buf_full && !evt.pop));

    a_occ_consistent: assert property (@(posedge clk) disable iff (reset)
        occ_q == buf_count + OCC_W'($countones(vpipe_q)));

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed phase table plus randomized soak, checked every cycle against a word-level scoreboard.
module tb_fifo_stream_reader;
    import fifo_stream_reader_pkg::*;

    localparam int DW = 32;
    localparam int L  = 1;
    localparam int BD = 4;
    localparam int PL = 4;
    localparam int CW = 16;
    localparam int OW = $clog2(BD) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [OW-1:0] occupancy;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus();

    fifo_stream_reader #(
        .DATA_WIDTH (DW),
        .RD_LATENCY (L),
        .BUF_DEPTH  (BD),
        .PACKET_LEN (PL),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.master),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            avail;   // first cycle the word may appear on the stream
    } exp_word_t;

    typedef struct {
        int cycles;
        bit rst;
        bit rdy;
        bit gate;
        int push;
        int e_pulses;
        int e_beats;
        int e_lasts;
        int e_occ;
        int e_valid;
        int e_data;
    } row_t;

    logic [DW-1:0] src[$];
    logic [DW-1:0] dl[$];
    exp_word_t     sb[$];

    bit rst_drv  = 1'b1;
    bit rdy_drv  = 1'b0;
    bit gate_drv = 1'b0;
    bit rst_prev = 1'b0;
    int cyc = 0;
    int beats = 0;
    int n_checks = 0;
    int n_fail = 0;
    int r_pulses, r_beats, r_lasts;
    int last_occ, last_valid;
    logic [DW-1:0] last_data;
    int next_w = 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // One clock: drive inputs mid-cycle, check settled outputs, then advance the model.
    task automatic step();
        bit            settled;
        bit            exp_v;
        bit            exp_rd;
        logic [DW-1:0] w;
        @(negedge clk);
        reset             = rst_drv;
        bus.m_axis_tready = rdy_drv;
        bus.fifo_rd_data  = dl.pop_front();
        bus.fifo_empty_n  = gate_drv && (src.size() > 0);
        #1;
        settled = !(rst_drv && !rst_prev);
        exp_v   = 1'b0;
        if (sb.size() > 0) begin
            exp_v = (sb[0].avail <= cyc);
        end
        exp_rd = !rst_drv && bus.fifo_empty_n && (sb.size() < BD);
        chk("rd_en", DW'(bus.fifo_rd_en), DW'(exp_rd));
        if (settled) begin
            chk("occupancy", DW'(occupancy), DW'(sb.size()));
            chk("tvalid", DW'(bus.m_axis_tvalid), DW'(exp_v));
            if (exp_v) begin
                chk("tdata", bus.m_axis_tdata, sb[0].data);
                chk("tlast", DW'(bus.m_axis_tlast), DW'((beats % PL) == PL - 1));
            end else if (rst_drv) begin
                chk("rst_tdata", bus.m_axis_tdata, '0);
                chk("rst_tlast", DW'(bus.m_axis_tlast), '0);
            end
        end
        last_occ   = int'(occupancy);
        last_valid = int'(bus.m_axis_tvalid);
        last_data  = bus.m_axis_tdata;

        if (bus.fifo_rd_en) begin
            r_pulses++;
            w = (src.size() > 0) ? src.pop_front() : $urandom;
            if (!rst_drv) sb.push_back('{data: w, avail: cyc + L + 1});
            dl.push_back(w);
        end else begin
            dl.push_back($urandom);
        end
        if (!rst_drv && bus.m_axis_tvalid && rdy_drv) begin
            r_beats++;
            if (bus.m_axis_tlast) r_lasts++;
        end
        if (!rst_drv && exp_v && rdy_drv) begin
            void'(sb.pop_front());
            beats++;
        end
        if (rst_drv) begin
            sb.delete();
            beats = 0;
        end
        rst_prev = rst_drv;
        cyc++;
    endtask

    row_t rows[12];

    initial begin
        //          cyc rst rdy gate push  pulses beats lasts occ valid data
        rows[0]  = '{3,  1, 0, 1, 16,   0,  0, 0,  0,  0, -1};
        rows[1]  = '{20, 0, 1, 1, 0,   16, 16, 4,  0,  0, -1};
        rows[2]  = '{8,  0, 0, 1, 16,   4,  0, 0,  4,  1, 17};
        rows[3]  = '{20, 0, 1, 1, 0,   12, 16, 4,  0,  0, -1};
        rows[4]  = '{6,  0, 1, 1, 3,    3,  3, 0,  0,  0, -1};
        rows[5]  = '{5,  0, 1, 0, 3,    0,  0, 0,  0,  0, -1};
        rows[6]  = '{6,  0, 1, 1, 0,    3,  3, 1,  0,  0, -1};
        rows[7]  = '{2,  1, 1, 1, 0,    0,  0, 0,  0,  0, -1};
        rows[8]  = '{14, 0, 1, 1, 10,  10, 10, 2,  0,  0, -1};
        rows[9]  = '{4,  0, 0, 1, 3,    3,  0, 0,  3,  1, 49};
        rows[10] = '{1,  1, 0, 1, 0,    0,  0, 0, -1, -1, -1};
        rows[11] = '{10, 0, 1, 1, 6,    6,  6, 1,  0,  0, -1};

        bus.m_axis_tready = 1'b0;
        bus.fifo_empty_n  = 1'b0;
        bus.fifo_rd_data  = '0;
        repeat (L) dl.push_back($urandom);

        for (int r = 0; r < 12; r++) begin
            repeat (rows[r].push) begin
                src.push_back(DW'(next_w));
                next_w++;
            end
            rst_drv  = rows[r].rst;
            rdy_drv  = rows[r].rdy;
            gate_drv = rows[r].gate;
            r_pulses = 0;
            r_beats  = 0;
            r_lasts  = 0;
            repeat (rows[r].cycles) step();
            $display("row %0d: rd_en pulses=%0d beats=%0d tlast=%0d occupancy=%0d tvalid=%0d tdata=0x%0h",
                     r, r_pulses, r_beats, r_lasts, last_occ, last_valid, last_data);
            if (rows[r].e_pulses >= 0) chk($sformatf("row%0d_pulses", r), DW'(r_pulses), DW'(rows[r].e_pulses));
            if (rows[r].e_beats  >= 0) chk($sformatf("row%0d_beats", r),  DW'(r_beats),  DW'(rows[r].e_beats));
            if (rows[r].e_lasts  >= 0) chk($sformatf("row%0d_lasts", r),  DW'(r_lasts),  DW'(rows[r].e_lasts));
            if (rows[r].e_occ    >= 0) chk($sformatf("row%0d_occ", r),    DW'(last_occ),   DW'(rows[r].e_occ));
            if (rows[r].e_valid  >= 0) chk($sformatf("row%0d_valid", r),  DW'(last_valid), DW'(rows[r].e_valid));
            if (rows[r].e_data   >= 0) chk($sformatf("row%0d_data", r),   last_data,       DW'(rows[r].e_data));
        end

        r_pulses = 0;
        r_beats  = 0;
        r_lasts  = 0;
        for (int i = 0; i < 3000; i++) begin
            rdy_drv  = ($urandom_range(0, 3) != 0);
            gate_drv = ($urandom_range(0, 7) != 0);
            rst_drv  = ($urandom_range(0, 499) == 0);
            if (src.size() < 6 && $urandom_range(0, 1) == 1) src.push_back($urandom);
            step();
        end
        rst_drv  = 1'b0;
        rdy_drv  = 1'b1;
        gate_drv = 1'b1;
        repeat (30) step();
        $display("soak: rd_en pulses=%0d beats=%0d tlast=%0d", r_pulses, r_beats, r_lasts);
        chk("drain_occupancy", DW'(last_occ), '0);
        chk("drain_tvalid", DW'(last_valid), '0);
        chk("drain_src_left", DW'(src.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
